// File: rtl/prog_onehot_fsm_pkg.sv
// Shared definitions for the programmable one-hot FSM: table select
// encodings and one-hot/index conversion helpers (sized for up to 16 states).
package prog_onehot_fsm_pkg;

  localparam logic CFG_SEL_NEXT = 1'b0;
  localparam logic CFG_SEL_CP   = 1'b1;

  // Binary state index to one-hot vector.
  function automatic logic [15:0] idx_to_onehot(input logic [3:0] idx);
    logic [15:0] v;
    v      = 16'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // One-hot vector to binary index (OR-reduction; meaningful only when one-hot).
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return (cnt == 5'd1);
  endfunction

endpackage

// File: rtl/fsm_table_ram.sv
// Next-state and control-point tables: synchronous write, combinational read.
// Reads of the current edge see the pre-write contents, so a transition and a
// write to the same entry in one cycle resolve to the old value.
module fsm_table_ram
  import prog_onehot_fsm_pkg::*;
#(
  parameter int NS  = 7,
  parameter int XW  = 2,
  parameter int CPW = 5,
  parameter int SW  = 3,
  parameter int DW  = 5
) (
  input  logic           clk,
  input  logic           i_clr,
  input  logic           i_we,
  input  logic           i_sel,
  input  logic [SW-1:0]  i_wr_state,
  input  logic [XW-1:0]  i_wr_x,
  input  logic [DW-1:0]  i_wr_data,
  input  logic [SW-1:0]  i_ns_state,
  input  logic [XW-1:0]  i_ns_x,
  output logic [SW-1:0]  o_ns_data,
  input  logic [SW-1:0]  i_cp_addr,
  output logic [CPW-1:0] o_cp_data
);

  localparam int NX = 2 ** XW;
  localparam logic [SW:0] NS_L = (SW + 1)'(NS);

  logic [SW-1:0]  r_next [NS][NX];
  logic [CPW-1:0] r_cp   [NS];

  logic w_wr_ok;
  logic w_ns_ok;
  logic w_cp_ok;

  assign w_wr_ok = ({1'b0, i_wr_state} < NS_L);
  assign w_ns_ok = ({1'b0, i_ns_state} < NS_L);
  assign w_cp_ok = ({1'b0, i_cp_addr}  < NS_L);

  // Table storage: clear wipes both tables and discards any concurrent write.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int s = 0; s < NS; s++) begin
        r_cp[s] <= {CPW{1'b0}};
        for (int c = 0; c < NX; c++) begin
          r_next[s][c] <= {SW{1'b0}};
        end
      end
    end else if (i_we && w_wr_ok) begin
      if (i_sel == CFG_SEL_NEXT) begin
        r_next[i_wr_state][i_wr_x] <= i_wr_data[SW-1:0];
      end else if (i_sel == CFG_SEL_CP) begin
        r_cp[i_wr_state] <= i_wr_data[CPW-1:0];
      end
    end
  end

  // Next-state lookup; out-of-range rows read as zero.
  always_comb begin
    if (w_ns_ok) begin
      o_ns_data = r_next[i_ns_state][i_ns_x];
    end else begin
      o_ns_data = {SW{1'b0}};
    end
  end

  // Control-point lookup; out-of-range rows read as zero.
  always_comb begin
    if (w_cp_ok) begin
      o_cp_data = r_cp[i_cp_addr];
    end else begin
      o_cp_data = {CPW{1'b0}};
    end
  end

endmodule

// File: rtl/prog_onehot_fsm.sv
// Programmable one-hot FSM. Present state is a one-hot register (all-zero is
// IDLE); the successor and its control points come from run-time tables and
// are loaded on the same edge. Illegal targets or a corrupted state vector
// fall back to state 0 and raise a sticky error flag.
module prog_onehot_fsm
  import prog_onehot_fsm_pkg::*;
#(
  parameter int NS  = 7,
  parameter int XW  = 2,
  parameter int CPW = 5
) (
  input  logic                                             clk,
  input  logic                                             clr,
  input  logic                                             start,
  input  logic                                             hold,
  input  logic [XW-1:0]                                    x,
  input  logic                                             cfg_we,
  input  logic                                             cfg_sel,
  input  logic [$clog2(NS)-1:0]                            cfg_state,
  input  logic [XW-1:0]                                    cfg_x,
  input  logic [(($clog2(NS) > CPW) ? $clog2(NS) : CPW)-1:0] cfg_data,
  output logic [NS-1:0]                                    yp,
  output logic [CPW-1:0]                                   cp,
  output logic                                             chg,
  output logic                                             err
);

  localparam int SW = $clog2(NS);
  localparam int DW = (SW > CPW) ? SW : CPW;
  localparam logic [SW:0] NS_L = (SW + 1)'(NS);

  logic [NS-1:0]  r_yp;
  logic [CPW-1:0] r_cp;
  logic           r_chg;
  logic           r_err;

  logic           w_yp_zero;
  logic           w_yp_legal;
  logic [SW-1:0]  w_cur_idx;
  logic [SW-1:0]  w_ns_raw;
  logic           w_ns_bad;
  logic [SW-1:0]  w_tgt;
  logic           w_go;
  logic [NS-1:0]  w_yp_nxt;
  logic           w_err_nxt;
  logic [CPW-1:0] w_cp_rd;
  logic [CPW-1:0] w_cp_nxt;
  logic           w_chg_nxt;

  assign w_yp_zero  = (r_yp == {NS{1'b0}});
  assign w_yp_legal = is_onehot(16'(r_yp));
  assign w_cur_idx  = SW'(onehot_to_idx(16'(r_yp)));
  assign w_ns_bad   = ({1'b0, w_ns_raw} >= NS_L);

  fsm_table_ram #(
    .NS  (NS),
    .XW  (XW),
    .CPW (CPW),
    .SW  (SW),
    .DW  (DW)
  ) u_tables (
    .clk        (clk),
    .i_clr      (clr),
    .i_we       (cfg_we),
    .i_sel      (cfg_sel),
    .i_wr_state (cfg_state),
    .i_wr_x     (cfg_x),
    .i_wr_data  (cfg_data),
    .i_ns_state (w_cur_idx),
    .i_ns_x     (x),
    .o_ns_data  (w_ns_raw),
    .i_cp_addr  (w_tgt),
    .o_cp_data  (w_cp_rd)
  );

  // State register: clear dominates; otherwise load the computed successors.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_yp  <= {NS{1'b0}};
      r_cp  <= {CPW{1'b0}};
      r_chg <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_yp  <= w_yp_nxt;
      r_cp  <= w_cp_nxt;
      r_chg <= w_chg_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Next-state selection: start > hold > idle > recovery > table advance.
  always_comb begin
    w_go      = 1'b0;
    w_tgt     = {SW{1'b0}};
    w_err_nxt = r_err;
    if (start) begin
      w_go = 1'b1;
    end else if (hold) begin
      w_go = 1'b0;
    end else if (w_yp_zero) begin
      w_go = 1'b0;
    end else if (!w_yp_legal || w_ns_bad) begin
      w_go      = 1'b1;
      w_err_nxt = 1'b1;
    end else begin
      w_go  = 1'b1;
      w_tgt = w_ns_raw;
    end
    if (w_go) begin
      w_yp_nxt = NS'(idx_to_onehot(4'(w_tgt)));
    end else begin
      w_yp_nxt = r_yp;
    end
  end

  // Output decode: control points track the target state; chg flags a change.
  always_comb begin
    if (w_go) begin
      w_cp_nxt = w_cp_rd;
    end else begin
      w_cp_nxt = r_cp;
    end
    w_chg_nxt = (w_yp_nxt != r_yp);
  end

  assign yp  = r_yp;
  assign cp  = r_cp;
  assign chg = r_chg;
  assign err = r_err;

endmodule

// File: tb/tb_prog_onehot_fsm.sv
// Directed self-checking bench for prog_onehot_fsm (NS=7, XW=2, CPW=5).
module tb_prog_onehot_fsm;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] x = 2'd0;
  logic       cfg_we = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [2:0] cfg_state = 3'd0;
  logic [1:0] cfg_x = 2'd0;
  logic [4:0] cfg_data = 5'd0;
  logic [6:0] yp;
  logic [4:0] cp;
  logic       chg;
  logic       err;

  int tests = 0;
  int fails = 0;

  int nxt [7][4];
  int cpt [7];

  prog_onehot_fsm #(.NS(7), .XW(2), .CPW(5)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .hold      (hold),
    .x         (x),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_state (cfg_state),
    .cfg_x     (cfg_x),
    .cfg_data  (cfg_data),
    .yp        (yp),
    .cp        (cp),
    .chg       (chg),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] oh(input int s);
    return 7'b1 << s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int st, input int cx, input int data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_state = 3'(st);
    cfg_x     = 2'(cx);
    cfg_data  = 5'(data);
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    // reference tables
    for (int s = 0; s < 7; s++) begin
      cpt[s] = (s * 7 + 5) % 32;
      for (int c = 0; c < 4; c++) begin
        nxt[s][c] = (s * 2 + c + 1) % 7;
      end
    end
    nxt[0][0] = 0; nxt[0][1] = 2; nxt[0][3] = 3; nxt[0][2] = 6;
    nxt[2][0] = 1;

    // reset
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("rst_yp", 32'(yp), 32'd0);
    chk("rst_cp", 32'(cp), 32'd0);
    chk("rst_chg", 32'(chg), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // program both tables while idle
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, s, c, nxt[s][c]);
      end
    end
    for (int s = 0; s < 7; s++) begin
      wr(1'b1, s, 0, cpt[s]);
    end

    // idle without start stays idle
    x = 2'b01;
    tick();
    x = 2'b11;
    tick();
    chk("idle_yp", 32'(yp), 32'd0);
    chk("idle_cp", 32'(cp), 32'd0);
    chk("idle_chg", 32'(chg), 32'd0);

    // start then walk 0 -> 2 -> 1
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_yp", 32'(yp), 32'(oh(0)));
    chk("start_cp", 32'(cp), 32'(cpt[0]));
    chk("start_chg", 32'(chg), 32'd1);
    x = 2'b01;
    tick();
    chk("adv1_yp", 32'(yp), 32'(7'b0000100));
    chk("adv1_cp", 32'(cp), 32'(cpt[2]));
    chk("adv1_chg", 32'(chg), 32'd1);
    x = 2'b00;
    tick();
    chk("adv2_yp", 32'(yp), 32'(7'b0000010));
    chk("adv2_cp", 32'(cp), 32'(cpt[1]));
    chk("adv2_chg", 32'(chg), 32'd1);

    // hold freezes state while x varies
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rest_yp", 32'(yp), 32'(oh(0)));
    chk("rest_chg", 32'(chg), 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = 2'(i + 1);
      tick();
      chk("hold_yp", 32'(yp), 32'(oh(0)));
      chk("hold_cp", 32'(cp), 32'(cpt[0]));
      chk("hold_chg", 32'(chg), 32'd0);
    end
    hold = 1'b0;

    // self-loop 0 -> 0 never pulses chg
    x = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("loop_yp", 32'(yp), 32'(oh(0)));
      chk("loop_chg", 32'(chg), 32'd0);
    end

    // write and use of the same entry in one cycle
    x = 2'b01;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_state = 3'd0; cfg_x = 2'b01; cfg_data = 5'd4;
    tick();
    cfg_we = 1'b0;
    chk("rw_old_yp", 32'(yp), 32'(oh(nxt[0][1])));
    chk("rw_old_cp", 32'(cp), 32'(cpt[nxt[0][1]]));
    nxt[0][1] = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rw_new_yp", 32'(yp), 32'(oh(4)));
    chk("rw_new_cp", 32'(cp), 32'(cpt[4]));
    chk("rw_new_chg", 32'(chg), 32'd1);

    // illegal target (7 >= NS) recovers to state 0 and sets err
    start = 1'b1;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_state = 3'd0; cfg_x = 2'b01; cfg_data = 5'd7;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    chk("pre_err_yp", 32'(yp), 32'(oh(0)));
    chk("pre_err_err", 32'(err), 32'd0);
    x = 2'b01;
    tick();
    chk("bad_yp", 32'(yp), 32'(oh(0)));
    chk("bad_cp", 32'(cp), 32'(cpt[0]));
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_chg", 32'(chg), 32'd0);
    x = 2'b00;
    tick();
    chk("err_sticky1", 32'(err), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_sticky2", 32'(err), 32'd1);
    hold = 1'b1;
    tick();
    hold = 1'b0;
    chk("err_sticky3", 32'(err), 32'd1);
    x = 2'b10;
    tick();
    chk("pre_clr_yp", 32'(yp), 32'(oh(nxt[0][2])));
    chk("pre_clr_err", 32'(err), 32'd1);

    // clear with concurrent start and write: clear wins, write discarded
    clr = 1'b1; start = 1'b1;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_state = 3'd0; cfg_x = 2'b00; cfg_data = 5'd3;
    tick();
    clr = 1'b0; start = 1'b0; cfg_we = 1'b0;
    chk("clr_yp", 32'(yp), 32'd0);
    chk("clr_cp", 32'(cp), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_chg", 32'(chg), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_clr_yp", 32'(yp), 32'(oh(0)));
    chk("post_clr_cp", 32'(cp), 32'd0);
    chk("post_clr_chg", 32'(chg), 32'd1);
    x = 2'b00;
    tick();
    chk("zeroed_x00_yp", 32'(yp), 32'(oh(0)));
    chk("zeroed_x00_chg", 32'(chg), 32'd0);
    x = 2'b10;
    tick();
    chk("zeroed_x10_yp", 32'(yp), 32'(oh(0)));
    chk("zeroed_x10_cp", 32'(cp), 32'd0);
    chk("zeroed_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
